// File: rtl/vm2002_supplier_loader.sv
// Supplier-side restock transmitter: walks a preloaded per-item table and emits one
// valid beat per non-empty entry, followed by a programmable idle gap.
module vm2002_supplier_loader #(
  parameter int NUM_ITEMS  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       hrst,
  input  logic       tbl_we,
  input  logic [2:0] tbl_addr,
  input  logic [3:0] tbl_count,
  input  logic [7:0] tbl_cost,
  input  logic       start,
  input  logic       vm_ready,
  output logic [2:0] item,
  output logic [3:0] count,
  output logic [7:0] cost,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] loaded_cnt,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {IDLE, SCAN, SEND, GAP, DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_ITEMS - 1);
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  // Handshake: a beat is offered only when vm_ready is high while scanning a
  // non-empty entry; the beat itself (valid=1) lasts exactly one cycle and is
  // never retracted, so vm_ready is ignored outside SCAN.

  state_t     state;
  logic [2:0] idx;
  logic [7:0] gap_cnt;
  logic [3:0] cnt_tbl  [8];
  logic [7:0] cost_tbl [8];
  logic       tbl_wr_ok;

  // Table is locked for the whole pass so every beat sees consistent values.
  assign tbl_wr_ok = tbl_we && (state == IDLE || state == DONE) &&
                     ({1'b0, tbl_addr} < 4'(NUM_ITEMS));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (hrst) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      item       <= '0;
      count      <= '0;
      cost       <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      loaded_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_tbl[i]  <= '0;
        cost_tbl[i] <= '0;
      end
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      item  <= '0;
      count <= '0;
      cost  <= '0;

      if (tbl_wr_ok) begin
        cnt_tbl[tbl_addr]  <= tbl_count;
        cost_tbl[tbl_addr] <= tbl_cost;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN;
            idx        <= '0;
            loaded_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt_tbl[idx] == 4'd0) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
            end
          end else if (vm_ready) begin
            state      <= SEND;
            valid      <= 1'b1;
            item       <= idx;
            count      <= cnt_tbl[idx];
            cost       <= cost_tbl[idx];
            loaded_cnt <= loaded_cnt + 4'd1;
          end
        end
        SEND: begin
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_LOAD;
          end else if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= SCAN;
            idx   <= idx + 3'd1;
          end
        end
        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= SCAN;
            idx   <= idx + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vm2002_supplier_loader.sv
// Directed bench for vm2002_supplier_loader: a cycle-by-cycle vector table for the
// basic pass plus hand-written sequences for gap-less scan, back-pressure, locking and reset.
module tb_vm2002_supplier_loader;

  logic       clk = 1'b0;
  logic       hrst, tbl_we, start, vm_ready;
  logic [2:0] tbl_addr;
  logic [3:0] tbl_count;
  logic [7:0] tbl_cost;

  logic [2:0] item, item0;
  logic [3:0] count, count0;
  logic [7:0] cost, cost0;
  logic       valid, valid0, busy, busy0, done, done0;
  logic [3:0] loaded_cnt, loaded_cnt0;
  logic [2:0] dbg_state, dbg_state0;

  always #5 clk = ~clk;

  vm2002_supplier_loader #(.NUM_ITEMS(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .hrst(hrst), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_count(tbl_count), .tbl_cost(tbl_cost), .start(start), .vm_ready(vm_ready),
    .item(item), .count(count), .cost(cost), .valid(valid), .busy(busy),
    .done(done), .loaded_cnt(loaded_cnt), .dbg_state(dbg_state)
  );

  vm2002_supplier_loader #(.NUM_ITEMS(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .hrst(hrst), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_count(tbl_count), .tbl_cost(tbl_cost), .start(start), .vm_ready(vm_ready),
    .item(item0), .count(count0), .cost(cost0), .valid(valid0), .busy(busy0),
    .done(done0), .loaded_cnt(loaded_cnt0), .dbg_state(dbg_state0)
  );

  typedef struct {
    logic        start;
    logic [17:0] exp;   // {valid, item, count, cost, busy, done}
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done0_cnt = 0;
  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];
  logic [14:0] exp0_q[$];
  logic [14:0] got0_q[$];
  int          got0_cyc_q[$];
  vec_t        t1 [16];

  function automatic logic [17:0] mk(logic v, logic [2:0] it, logic [3:0] c,
                                     logic [7:0] co, logic b, logic d);
    return {v, it, c, co, b, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one cycle and record everything observable from both instances.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) got_q.push_back({item, count, cost});
    if (valid0) begin
      got0_q.push_back({item0, count0, cost0});
      got0_cyc_q.push_back(cyc);
    end
    if (done) done_cnt++;
    if (done0) done0_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] c, input logic [7:0] co);
    tbl_we = 1'b1; tbl_addr = a; tbl_count = c; tbl_cost = co;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic do_reset();
    hrst = 1'b1;
    tick();
    hrst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: compare recorded beats against the expected queue, then clear both.
  task automatic check_beats(input string name, input bit sel);
    logic [14:0] e[$];
    logic [14:0] g[$];
    int n;
    if (sel) begin e = exp0_q; g = got0_q; end
    else begin e = exp_q; g = got_q; end
    check($sformatf("%s_beats_n", name), 32'(g.size()), 32'(e.size()));
    n = (g.size() < e.size()) ? g.size() : e.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", name, i), 32'(g[i]), 32'(e[i]));
    if (sel) begin exp0_q.delete(); got0_q.delete(); got0_cyc_q.delete(); end
    else begin exp_q.delete(); got_q.delete(); end
  endtask

  initial begin
    int d, d0, n;
    hrst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_count = '0; tbl_cost = '0;
    start = 1'b0; vm_ready = 1'b1;

    for (int i = 0; i < 16; i++) t1[i] = '{1'b0, mk(1'b0, 3'd0, 4'd0, 8'd0, 1'b1, 1'b0)};
    t1[0].start = 1'b1;
    t1[1].exp   = mk(1'b1, 3'd0, 4'd3, 8'd25, 1'b1, 1'b0);
    t1[9].exp   = mk(1'b1, 3'd5, 4'd9, 8'd100, 1'b1, 1'b0);
    t1[14].exp  = mk(1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 1'b1);
    t1[15].exp  = mk(1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 1'b0);

    // Reset state
    tick(); tick();
    check("rst_outputs", 32'({valid, busy, done, item, count, cost, loaded_cnt}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    hrst = 1'b0;

    // T1: two populated entries, gap of 2, cycle-accurate vector table
    wr(3'd0, 4'd3, 8'd25);
    wr(3'd5, 4'd9, 8'd100);
    exp_q.push_back({3'd0, 4'd3, 8'd25});
    exp_q.push_back({3'd5, 4'd9, 8'd100});
    d = done_cnt;
    for (int i = 0; i < 16; i++) begin
      start = t1[i].start;
      tick();
      check($sformatf("t1_v%0d", i), 32'({valid, item, count, cost, busy, done}), 32'(t1[i].exp));
    end
    start = 1'b0;
    check("t1_loaded", 32'(loaded_cnt), 32'd2);
    check("t1_done_pulses", 32'(done_cnt - d), 32'd1);
    check_beats("t1", 1'b0);

    // T2: empty table, done after NUM_ITEMS scan cycles
    do_reset();
    pulse_start();
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check("t2_done_latency", 32'(n), 32'd8);
    check("t2_loaded", 32'(loaded_cnt), 32'd0);
    check_beats("t2", 1'b0);

    // T3: all entries full; gap-less instance sends on every other cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 4'd15, 8'(i * 10 + 1));
      exp_q.push_back({3'(i), 4'd15, 8'(i * 10 + 1)});
      exp0_q.push_back({3'(i), 4'd15, 8'(i * 10 + 1)});
    end
    got_q.delete(); got0_q.delete(); got0_cyc_q.delete();
    d = done_cnt; d0 = done0_cnt;
    pulse_start();
    run(60);
    for (int i = 1; i < got0_cyc_q.size(); i++)
      check($sformatf("t3_spacing%0d", i), 32'(got0_cyc_q[i] - got0_cyc_q[i-1]), 32'd2);
    check_beats("t3_gap0", 1'b1);
    check_beats("t3_gap2", 1'b0);
    check("t3_loaded_gap0", 32'(loaded_cnt0), 32'd8);
    check("t3_loaded_gap2", 32'(loaded_cnt), 32'd8);
    check("t3_done_gap0", 32'(done0_cnt - d0), 32'd1);
    check("t3_done_gap2", 32'(done_cnt - d), 32'd1);

    // T4: back-pressure holds the scan at entry 2
    do_reset();
    wr(3'd2, 4'd4, 8'd50);
    exp_q.push_back({3'd2, 4'd4, 8'd50});
    vm_ready = 1'b0;
    pulse_start();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t4_hold%0d", i), 32'({valid, busy, dbg_state}), 32'({1'b0, 1'b1, 3'd1}));
    end
    vm_ready = 1'b1;
    tick();
    check("t4_beat", 32'({valid, item, count, cost}), 32'({1'b1, 3'd2, 4'd4, 8'd50}));
    run(30);
    check("t4_loaded", 32'(loaded_cnt), 32'd1);
    check_beats("t4", 1'b0);

    // T5: write and start while busy are both ignored
    do_reset();
    wr(3'd3, 4'd5, 8'd77);
    exp_q.push_back({3'd3, 4'd5, 8'd77});
    d = done_cnt;
    pulse_start();
    tick(); tick();
    tbl_we = 1'b1; tbl_addr = 3'd3; tbl_count = 4'd1; tbl_cost = 8'd1; start = 1'b1;
    tick();
    tbl_we = 1'b0; start = 1'b0;
    run(40);
    check("t5_done_pulses", 32'(done_cnt - d), 32'd1);
    check("t5_loaded", 32'(loaded_cnt), 32'd1);
    check_beats("t5a", 1'b0);
    exp_q.push_back({3'd3, 4'd5, 8'd77});
    pulse_start();
    run(40);
    check_beats("t5b", 1'b0);
    check("t5_done_pulses2", 32'(done_cnt - d), 32'd2);

    // T6: reset while in GAP abandons the pass and clears the table
    do_reset();
    wr(3'd0, 4'd3, 8'd25);
    wr(3'd5, 4'd9, 8'd100);
    exp_q.push_back({3'd0, 4'd3, 8'd25});
    pulse_start();
    tick(); tick();
    check("t6_in_gap", 32'(dbg_state), 32'd3);
    hrst = 1'b1;
    tick();
    hrst = 1'b0;
    check("t6_rst_outputs", 32'({valid, busy, done, item, count, cost, loaded_cnt}), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    run(20);
    check_beats("t6a", 1'b0);
    d = done_cnt;
    pulse_start();
    run(20);
    check("t6_done_pulses", 32'(done_cnt - d), 32'd1);
    check("t6_loaded", 32'(loaded_cnt), 32'd0);
    check_beats("t6b", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
